// File: rtl/noc3_out_credit_buf.sv
// noc3_out_credit_buf: flit FIFO toward a NoC3 router with credit flow control.
// One flit per cycle leaves while the downstream router has buffer credits.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module noc3_out_credit_buf #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  parameter int DATA_W  = `NOC_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              noc3encoder_noc3out_val,
  input  logic [DATA_W-1:0] noc3encoder_noc3out_data,
  output logic              noc3out_ready,
  output logic              noc3_out_val,
  output logic [DATA_W-1:0] noc3_out_data,
  input  logic              noc3_out_yummy,
  output logic              buf_empty,
  output logic [3:0]        credit_cnt,
  output logic              err_credit_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LP_DEPTH = DEPTH[AW:0];
  localparam logic [AW:0]   LP_OCC1  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LP_PTR1  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [3:0]    LP_CRED  = CREDITS[3:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_occ;
  logic [3:0]        r_credit;
  logic              r_ovf;
  logic              r_val;
  logic [DATA_W-1:0] r_data;

  logic w_wr;
  logic w_send;

  assign noc3out_ready  = (r_occ < LP_DEPTH);
  assign buf_empty      = (r_occ == '0);
  assign w_wr           = noc3encoder_noc3out_val && noc3out_ready;
  assign w_send         = !buf_empty && (r_credit != 4'd0);
  assign noc3_out_val   = r_val;
  assign noc3_out_data  = r_data;
  assign credit_cnt     = r_credit;
  assign err_credit_ovf = r_ovf;

  // Flit storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= noc3encoder_noc3out_data;
  end

  // Pointers and occupancy; a write and send together leave occupancy as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr)   r_wr_ptr <= r_wr_ptr + LP_PTR1;
      if (w_send) r_rd_ptr <= r_rd_ptr + LP_PTR1;
      unique case ({w_wr, w_send})
        2'b10:   r_occ <= r_occ + LP_OCC1;
        2'b01:   r_occ <= r_occ - LP_OCC1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Credit counter; a return at full credit saturates and flags an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit <= LP_CRED;
      r_ovf    <= 1'b0;
    end else if (w_send && !noc3_out_yummy) begin
      r_credit <= r_credit - 4'd1;
    end else if (!w_send && noc3_out_yummy) begin
      if (r_credit == LP_CRED) r_ovf <= 1'b1;
      else                     r_credit <= r_credit + 4'd1;
    end
  end

  // Output register: one-cycle valid pulse per sent flit, data held between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val  <= 1'b0;
      r_data <= '0;
    end else begin
      r_val <= w_send;
      if (w_send) r_data <= r_mem[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_noc3_out_credit_buf.sv
// tb_noc3_out_credit_buf: randomized and directed stimulus against a
// queue-based reference model, outputs checked by a scoreboard monitor.
module tb_noc3_out_credit_buf;

  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;
  localparam int DW      = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_val = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          ready;
  logic          out_val;
  logic [DW-1:0] out_data;
  logic          yummy = 1'b0;
  logic          empty;
  logic [3:0]    cred;
  logic          ovf;

  always #5 clk = ~clk;

  noc3_out_credit_buf #(
    .DEPTH(DEPTH), .CREDITS(CREDITS), .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .noc3encoder_noc3out_val(in_val),
    .noc3encoder_noc3out_data(in_data),
    .noc3out_ready(ready),
    .noc3_out_val(out_val),
    .noc3_out_data(out_data),
    .noc3_out_yummy(yummy),
    .buf_empty(empty),
    .credit_cnt(cred),
    .err_credit_ovf(ovf)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_fifo[$];
  logic [DW-1:0] exp_q[$];
  int  m_cred = CREDITS;
  bit  m_ovf = 1'b0;
  bit  exp_val = 1'b0;
  bit  mon_en = 1'b0;
  bit  t_acc;
  bit  t_dv;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares registered outputs against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready", ready, m_fifo.size() < DEPTH);
      chk("empty", empty, m_fifo.size() == 0);
      chk("credit", cred, m_cred);
      chk("ovf", ovf, m_ovf);
      chk("val", out_val, exp_val);
      if (out_val) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_flit: got %0h expected none at %0t",
                   out_data, $time);
        end else begin
          chk("data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus; the model advances by the rules of one edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit y,
                      output bit acc, output bit dv);
    bit snd;
    @(negedge clk);
    #1;
    dv = out_val;
    in_val = v;
    in_data = d;
    yummy = y;
    acc = v && (m_fifo.size() < DEPTH);
    snd = (m_fifo.size() > 0) && (m_cred > 0);
    if (snd) exp_q.push_back(m_fifo.pop_front());
    exp_val = snd;
    if (acc) m_fifo.push_back(d);
    if (snd && !y) m_cred--;
    else if (y && !snd) begin
      if (m_cred == CREDITS) m_ovf = 1'b1;
      else m_cred++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, t_acc, t_dv);
  endtask

  // Asynchronous reset after the next edge, checking outputs before any clock.
  task automatic do_reset(input string tag);
    mon_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_val"}, out_val, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_cred"}, cred, CREDITS);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_ready"}, ready, 1);
    in_val = 1'b0;
    in_data = '0;
    yummy = 1'b0;
    m_fifo.delete();
    exp_q.delete();
    m_cred = CREDITS;
    m_ovf = 1'b0;
    exp_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    bit h1;
    bit h2;
    int idx;
    int vcnt;
    logic [DW-1:0] d;

    #1 rst_n = 1'b0;
    #1;
    chk("por_val", out_val, 0);
    chk("por_cred", cred, CREDITS);
    chk("por_empty", empty, 1);
    chk("por_ready", ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    mon_en = 1'b1;

    // single flit
    step(1, 32'h1, 0, t_acc, t_dv);
    idle(3);
    chk("single_cred", cred, 3);

    // six-flit stream, credits run dry, then returned one at a time
    do_reset("r1");
    for (int i = 0; i < 6; i++) step(1, 32'h10 + i, 0, t_acc, t_dv);
    idle(3);
    chk("stall_cred", cred, 0);
    chk("stall_empty", empty, 0);
    step(0, '0, 1, t_acc, t_dv);
    idle(2);
    step(0, '0, 1, t_acc, t_dv);
    idle(2);

    // no credits: FIFO fills, fifth held flit is refused
    do_reset("r2");
    for (int i = 0; i < 4; i++) step(1, 32'h20 + i, 0, t_acc, t_dv);
    for (int i = 0; i < 6; i++) step(1, 32'h30 + i, 0, t_acc, t_dv);
    chk("full_ready", ready, 0);
    for (int i = 0; i < 6; i++) step(1, 32'h35, 1, t_acc, t_dv);
    idle(4);

    // yummy coinciding with send, then overflow at full credit
    do_reset("r3");
    step(1, 32'hA, 0, t_acc, t_dv);
    step(1, 32'hB, 0, t_acc, t_dv);
    step(1, 32'hC, 0, t_acc, t_dv);
    step(0, '0, 1, t_acc, t_dv);
    idle(1);
    chk("both_cred", cred, 2);
    step(0, '0, 1, t_acc, t_dv);
    step(0, '0, 1, t_acc, t_dv);
    step(0, '0, 1, t_acc, t_dv);
    idle(3);
    chk("ovf_set", ovf, 1);
    chk("ovf_cred", cred, CREDITS);

    // random traffic with random credit returns
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 4) == 0,
           t_acc, t_dv);
    end
    for (int i = 0; i < 50 && !exp_val; i++)
      step(1, $urandom, 0, t_acc, t_dv);
    do_reset("r4");

    // two flits buffered with one credit at the moment of reset
    for (int i = 0; i < 6; i++) step(1, 32'h40 + i, 0, t_acc, t_dv);
    step(0, '0, 1, t_acc, t_dv);
    do_reset("r5");

    // router echoes a credit two cycles after each flit
    h1 = 1'b0;
    h2 = 1'b0;
    idx = 0;
    vcnt = 0;
    d = $urandom;
    for (int i = 0; i < 90; i++) begin
      step(idx < 64, d, h2, t_acc, t_dv);
      h2 = h1;
      h1 = t_dv;
      if (t_acc) begin
        idx++;
        d = $urandom;
      end
      if (i >= 8 && i < 48 && t_dv) vcnt++;
    end
    chk("echo_tput", vcnt, 40);
    chk("echo_all_in", idx, 64);
    idle(2);
    chk("drain_fifo", m_fifo.size(), 0);
    chk("drain_sb", exp_q.size(), 0);
    chk("echo_cred", cred, CREDITS);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
